// File: rtl/spi_reg_ctrl_if.sv
// Register-bus bundle between spi_reg_ctrl (master) and a register file (slave).
// Ports: req/we/addr/wdata from the master; gnt/rvalid/rdata back from the slave.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
) ();
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [7:0]        bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [7:0]        bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder: command byte + auto-incrementing data bytes -> 8-bit register bus.
// Ports: clk_i/rst_ni, cs_i, rx_dv_i/rx_byte_i in, tx_dv_o/tx_byte_o out, bus (master), busy/err status.
module spi_reg_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cs_i,
    input  logic           rx_dv_i,
    input  logic [7:0]     rx_byte_i,
    output logic           tx_dv_o,
    output logic [7:0]     tx_byte_o,
    output logic           busy_o,
    output logic           err_o,
    output logic [1:0]     err_code_o,
    input  logic           err_clr_i,
    spi_reg_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_REQ, RD_REQ, RD_WAIT, RD_NEXT, DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        cnt;
    logic              req, we, pend, boot;
    logic              cs_q1, cs_q2, cs_q3;
    logic              frame_end, in_bus, done, fin, tmo, ovr, go_idle;
    logic              err_n;
    logic [1:0]        code_n;
    logic [7:0]        status;

    // cs_q3 is the previous synchronized value, for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_q1 <= 1'b1;
            cs_q2 <= 1'b1;
            cs_q3 <= 1'b1;
        end else begin
            cs_q1 <= cs_i;
            cs_q2 <= cs_q1;
            cs_q3 <= cs_q2;
        end
    end

    assign frame_end = cs_q2 & ~cs_q3;

    always_comb begin
        in_bus = (state == WR_REQ) || (state == RD_REQ) || (state == RD_WAIT);
        case (state)
            WR_REQ, RD_REQ: done = req & bus.bus_gnt_i;
            RD_WAIT:        done = bus.bus_rvalid_i;
            default:        done = 1'b0;
        endcase
        fin = pend | frame_end;
        tmo = in_bus & ~done & (cnt == 8'(TIMEOUT));
        ovr = in_bus & rx_dv_i & ~frame_end;
        // Clear first so that a new error in the same cycle overrides it.
        err_n  = err_o;
        code_n = err_code_o;
        if (err_clr_i) begin
            err_n  = 1'b0;
            code_n = 2'b00;
        end
        if (ovr) begin
            err_n  = 1'b1;
            code_n = 2'b01;
        end
        if (tmo) begin
            err_n  = 1'b1;
            code_n = 2'b10;
        end
        status = {err_n, code_n, 5'b0};
        // A read grant with the frame already closed still waits for rvalid.
        case (state)
            WR_DATA, RD_NEXT, DRAIN: go_idle = frame_end;
            WR_REQ:  go_idle = fin & (tmo | done);
            RD_REQ:  go_idle = fin & tmo;
            RD_WAIT: go_idle = fin & (tmo | done);
            default: go_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            addr       <= '0;
            wdata      <= '0;
            cnt        <= '0;
            req        <= 1'b0;
            we         <= 1'b0;
            pend       <= 1'b0;
            boot       <= 1'b1;
            tx_dv_o    <= 1'b0;
            tx_byte_o  <= '0;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
        end else begin
            boot       <= 1'b0;
            tx_dv_o    <= boot;
            err_o      <= err_n;
            err_code_o <= code_n;
            cnt        <= cnt + 8'd1;
            if (boot) tx_byte_o <= status;
            if (in_bus && frame_end) pend <= 1'b1;
            if (go_idle) begin
                state     <= IDLE;
                req       <= 1'b0;
                we        <= 1'b0;
                pend      <= 1'b0;
                tx_dv_o   <= 1'b1;
                tx_byte_o <= status;
            end else begin
                case (state)
                    IDLE: if (rx_dv_i && !frame_end) begin
                        addr  <= ADDR_W'(rx_byte_i[6:0]);
                        cnt   <= '0;
                        pend  <= 1'b0;
                        state <= rx_byte_i[7] ? WR_DATA : RD_REQ;
                    end
                    WR_DATA: if (rx_dv_i) begin
                        wdata <= rx_byte_i;
                        cnt   <= '0;
                        state <= WR_REQ;
                    end
                    WR_REQ: if (tmo) begin
                        req   <= 1'b0;
                        we    <= 1'b0;
                        state <= DRAIN;
                    end else if (done) begin
                        req   <= 1'b0;
                        we    <= 1'b0;
                        addr  <= addr + ADDR_W'(1);
                        state <= WR_DATA;
                    end else begin
                        req <= 1'b1;
                        we  <= 1'b1;
                    end
                    RD_REQ: if (tmo) begin
                        req   <= 1'b0;
                        state <= DRAIN;
                    end else if (done) begin
                        req   <= 1'b0;
                        cnt   <= '0;
                        state <= RD_WAIT;
                    end else begin
                        req <= 1'b1;
                        we  <= 1'b0;
                    end
                    RD_WAIT: if (tmo) begin
                        state <= DRAIN;
                    end else if (done) begin
                        tx_byte_o <= bus.bus_rdata_i;
                        tx_dv_o   <= 1'b1;
                        addr      <= addr + ADDR_W'(1);
                        state     <= RD_NEXT;
                    end
                    RD_NEXT: if (rx_dv_i) begin
                        cnt   <= '0;
                        state <= RD_REQ;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o          = (state != IDLE);
    assign bus.bus_req_o   = req;
    assign bus.bus_we_o    = we;
    assign bus.bus_addr_o  = addr;
    assign bus.bus_wdata_o = wdata;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: random and directed SPI frames against a memory model.
// Expected bus ops and TX bytes are queued by stimulus and checked by separate monitors.
module tb_spi_reg_ctrl;
    localparam int GAP = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       err_clr = 1'b0;
    logic       tx_dv, busy, err;
    logic [7:0] tx_byte;
    logic [1:0] err_code;

    spi_reg_ctrl_if #(.ADDR_W(7)) bus_if ();

    spi_reg_ctrl #(.ADDR_W(7), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cs_i(cs),
        .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
        .tx_dv_o(tx_dv), .tx_byte_o(tx_byte),
        .busy_o(busy), .err_o(err), .err_code_o(err_code),
        .err_clr_i(err_clr), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  env_mem [128];
    logic [7:0]  ref_mem [128];
    logic [7:0]  exp_tx [$];
    logic [15:0] exp_bus [$];
    logic        model_err = 1'b0;
    logic [1:0]  model_code = 2'b00;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic        hold_gnt = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    // Bus slave plus bus-side monitor: every granted request is a DUT output.
    initial begin : responder
        int          g_cnt;
        int          rv_cnt;
        bit          rv_pend;
        logic [6:0]  rv_addr;
        logic [15:0] got, e;
        g_cnt = 0; rv_cnt = 0; rv_pend = 0; rv_addr = '0;
        bus_if.bus_gnt_i = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            bus_if.bus_gnt_i = 1'b0;
            bus_if.bus_rvalid_i = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i = env_mem[rv_addr];
                    rv_pend = 0;
                end else rv_cnt--;
            end else if (bus_if.bus_req_o && !hold_gnt) begin
                if (g_cnt >= gnt_delay) begin
                    g_cnt = 0;
                    bus_if.bus_gnt_i = 1'b1;
                    got = {bus_if.bus_we_o, bus_if.bus_addr_o,
                           bus_if.bus_we_o ? bus_if.bus_wdata_o : 8'h00};
                    if (exp_bus.size() == 0) fail("bus_extra_op", got);
                    else begin
                        e = exp_bus.pop_front();
                        chk("bus_op", got, e);
                    end
                    if (bus_if.bus_we_o)
                        env_mem[bus_if.bus_addr_o] = bus_if.bus_wdata_o;
                    else begin
                        rv_pend = 1;
                        rv_cnt = rv_delay;
                        rv_addr = bus_if.bus_addr_o;
                    end
                end else g_cnt++;
            end else g_cnt = 0;
        end
    end

    initial begin : tx_mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                if (exp_tx.size() == 0) fail("tx_extra", tx_byte);
                else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", tx_byte, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic frame_open();
        @(negedge clk);
        cs = 1'b0;
        cycles(6);
    endtask

    task automatic frame_close();
        exp_tx.push_back({model_err, model_code, 5'b0});
        cs = 1'b1;
        cycles(10);
        chk("frame_idle_busy", busy, 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 1'b0;
        model_code = 2'b00;
        chk("err_clr_err", err, 0);
        chk("err_clr_code", err_code, 0);
    endtask

    task automatic wr_frame(input logic [6:0] a, input int n,
                            input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] d;
        logic [6:0] p;
        p = a;
        frame_open();
        send({1'b1, a});
        cycles(GAP);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom);
            exp_bus.push_back({1'b1, p, d});
            ref_mem[p] = d;
            p = p + 7'd1;
            send(d);
            cycles(GAP);
        end
        frame_close();
    endtask

    task automatic rd_frame(input logic [6:0] a, input int n);
        logic [6:0] p;
        p = a;
        frame_open();
        exp_bus.push_back({1'b0, p, 8'h00});
        exp_tx.push_back(ref_mem[p]);
        send({1'b0, a});
        cycles(GAP);
        for (int i = 0; i < n; i++) begin
            p = p + 7'd1;
            exp_bus.push_back({1'b0, p, 8'h00});
            exp_tx.push_back(ref_mem[p]);
            send(8'($urandom));
            cycles(GAP);
        end
        frame_close();
    endtask

    initial begin : stim
        int  hi, any_req;
        bit  seen, fell;
        logic [7:0] v;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[7'h7F] = 8'hAB; ref_mem[7'h7F] = 8'hAB;
        env_mem[7'h00] = 8'hCD; ref_mem[7'h00] = 8'hCD;
        env_mem[7'h20] = 8'h5C; ref_mem[7'h20] = 8'h5C;

        // Reset: a single status pulse of 0x00 follows release.
        cycles(3);
        exp_tx.push_back(8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_req", bus_if.bus_req_o, 0);
        chk("reset_err", err, 0);
        cycles(4);
        chk("reset_status_seen", exp_tx.size(), 0);

        // Directed write burst and wrapping read.
        wr_frame(7'h05, 2, 8'h11, 8'h22);
        rd_frame(7'h7F, 1);

        // Bus timeout on a read.
        hold_gnt = 1'b1;
        frame_open();
        send(8'h10);
        hi = 0; seen = 0; fell = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus_if.bus_req_o) begin
                seen = 1;
                hi++;
            end else if (seen) begin
                fell = 1;
                break;
            end
        end
        chk("tmo_req_dropped", fell, 1);
        chk("tmo_req_len_ok", int'(hi >= 254 && hi <= 256), 1);
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 2);
        chk("tmo_busy_drain", busy, 1);
        hold_gnt = 1'b0;
        send(8'h90);
        any_req = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_if.bus_req_o) any_req = 1;
        end
        chk("drain_no_req", any_req, 0);
        model_err = 1'b1;
        model_code = 2'b10;
        frame_close();
        clear_err();

        // Overrun during a slow write grant.
        gnt_delay = 10;
        frame_open();
        send(8'h83);
        cycles(GAP);
        exp_bus.push_back({1'b1, 7'h03, 8'h5A});
        ref_mem[7'h03] = 8'h5A;
        send(8'h5A);
        cycles(2);
        send(8'hEE);
        cycles(1);
        chk("ovr_err", err, 1);
        chk("ovr_code", err_code, 1);
        chk("ovr_busy", busy, 1);
        cycles(GAP);
        model_err = 1'b1;
        model_code = 2'b01;
        frame_close();
        clear_err();
        gnt_delay = 0;

        // Frame end while waiting for rvalid: data dropped, status only.
        rv_delay = 12;
        frame_open();
        exp_bus.push_back({1'b0, 7'h20, 8'h00});
        send(8'h20);
        seen = 0; fell = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_if.bus_req_o) seen = 1;
            else if (seen) begin
                fell = 1;
                break;
            end
        end
        chk("rdwait_granted", fell, 1);
        exp_tx.push_back(8'h00);
        cs = 1'b1;
        cycles(30);
        chk("rdwait_idle", busy, 0);
        chk("rdwait_tx_left", exp_tx.size(), 0);

        // Random frames.
        for (int f = 0; f < 16; f++) begin
            gnt_delay = $urandom_range(0, 5);
            rv_delay = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1)
                wr_frame(7'($urandom), $urandom_range(1, 3),
                         8'($urandom), 8'($urandom));
            else
                rd_frame(7'($urandom), $urandom_range(0, 3));
        end

        cycles(20);
        chk("exp_bus_drained", exp_bus.size(), 0);
        chk("exp_tx_drained", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
